// File: rtl/rr_sel4_4b.sv
// Round-robin selector for four N-bit request channels feeding an internal
// 4-1 mux, with a one-word output register behind a valid/ready handshake.

module mux4_1_4b #(
  parameter int N = 4
) (
  input  logic [N-1:0] InA,
  input  logic [N-1:0] InB,
  input  logic [N-1:0] InC,
  input  logic [N-1:0] InD,
  input  logic [1:0]   S,
  output logic [N-1:0] Out
);
  always_comb begin
    Out = InA;
    case (S)
      2'd0: Out = InA;
      2'd1: Out = InB;
      2'd2: Out = InC;
      2'd3: Out = InD;
      default: Out = InA;
    endcase
  end
endmodule

module rr_sel4_4b #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [N-1:0] InA,
  input  logic [N-1:0] InB,
  input  logic [N-1:0] InC,
  input  logic [N-1:0] InD,
  input  logic         out_ready,
  output logic [1:0]   S,
  output logic [3:0]   grant,
  output logic [N-1:0] Out,
  output logic         out_valid,
  output logic [1:0]   out_src
);
  // Handshake: Out/out_src are transferred on any rising edge where
  // out_valid=1 and out_ready=1; a new word may be loaded on that same edge.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state;
  logic   [1:0]   ptr;
  logic   [1:0]   win;
  logic           found;
  logic           any;
  logic           load;
  logic   [N-1:0] sel_data;

  assign any       = |req;
  assign out_valid = (state == FULL);

  // Scan from the pointer upward so the most recently served channel is last.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        win   = ptr + 2'(i);
        found = 1'b1;
      end
    end
  end

  assign S     = any ? win : ptr;
  assign load  = any & (~out_valid | out_ready) & ~rst;
  assign grant = load ? (4'b0001 << win) : 4'b0000;

  mux4_1_4b #(.N(N)) u_mux (
    .InA (InA),
    .InB (InB),
    .InC (InC),
    .InD (InD),
    .S   (S),
    .Out (sel_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      Out     <= '0;
      out_src <= 2'd0;
      ptr     <= 2'd0;
    end else if (load) begin
      state   <= FULL;
      Out     <= sel_data;
      out_src <= win;
      ptr     <= win + 2'd1;
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_rr_sel4_4b.sv
// Self-checking bench for rr_sel4_4b: directed plan steps plus random traffic,
// compared each cycle against a behavioural arbitration model.

module tb_rr_sel4_4b;
  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [N-1:0] InA, InB, InC, InD;
  logic         out_ready;
  logic [1:0]   S;
  logic [3:0]   grant;
  logic [N-1:0] Out;
  logic         out_valid;
  logic [1:0]   out_src;

  int n_checks;
  int n_fail;

  // Model state: served-pointer as an integer and the output register content.
  int           m_ptr;
  bit           m_valid;
  int           m_out;
  int           m_src;
  logic [N-1:0] exp_q[$];

  rr_sel4_4b #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .InA       (InA),
    .InB       (InB),
    .InC       (InC),
    .InD       (InD),
    .out_ready (out_ready),
    .S         (S),
    .grant     (grant),
    .Out       (Out),
    .out_valid (out_valid),
    .out_src   (out_src)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int chan_data(input int idx);
    case (idx)
      0: return int'(InA);
      1: return int'(InB);
      2: return int'(InC);
      default: return int'(InD);
    endcase
  endfunction

  // One clock: check combinational outputs, clock the edge, check registers.
  task automatic cycle();
    int  win;
    bit  any;
    bit  ld;
    int  e_grant;
    int  e_s;
    #1;
    any = (req != 4'b0000);
    win = m_ptr;
    for (int k = 3; k >= 0; k--)
      if (req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    ld      = any && (!m_valid || out_ready) && !rst;
    e_grant = ld ? (1 << win) : 0;
    e_s     = any ? win : m_ptr;
    check("grant", 8'(grant), 8'(e_grant));
    check("S", 8'(S), 8'(e_s));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_out = 0; m_src = 0; m_ptr = 0;
      exp_q.delete();
    end else if (ld) begin
      m_out   = chan_data(win);
      m_src   = win;
      m_valid = 1;
      m_ptr   = (win + 1) % 4;
      exp_q.push_back(N'(m_out));
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    #1;
    check("out_valid", 8'(out_valid), 8'(m_valid));
    check("Out", 8'(Out), 8'(m_out));
    check("out_src", 8'(out_src), 8'(m_src));
  endtask

  // driver task
  task automatic drive(input logic [3:0] r, input logic rdy, input logic rs);
    req = r; out_ready = rdy; rst = rs;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_ptr = 0; m_valid = 0; m_out = 0; m_src = 0;
    InA = 4'h1; InB = 4'h2; InC = 4'h3; InD = 4'h4;

    // 1. reset with all requests pending
    drive(4'b1111, 1'b1, 1'b1);
    cycle();
    cycle();
    drive(4'b1111, 1'b1, 1'b0);
    #1;
    check("rel_grant", 8'(grant), 8'h01);
    check("rel_S", 8'(S), 8'h00);
    drive(4'b0000, 1'b1, 1'b0);
    cycle();

    // 2. single request on C
    InC = 4'hA;
    drive(4'b0100, 1'b1, 1'b0);
    cycle();
    check("single_out", 8'(Out), 8'h0A);
    check("single_src", 8'(out_src), 8'h02);

    // 3. round-robin wrap from ptr 0
    drive(4'b1111, 1'b1, 1'b1);
    cycle();
    InA = 4'h1; InB = 4'h2; InC = 4'h3; InD = 4'h4;
    drive(4'b1111, 1'b1, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 6; i++) cycle();
    check("rr_len", 8'(exp_q.size()), 8'd6);
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] rr_seq [6];
      rr_seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2};
      if (i < exp_q.size()) check("rr_seq", 8'(exp_q[i]), 8'(rr_seq[i]));
    end

    // 4. backpressure: load B, stall 3 cycles, release -> C
    InB = 4'h5;
    drive(4'b0010, 1'b1, 1'b0);
    cycle();
    drive(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_out", 8'(Out), 8'h05);
    end
    drive(4'b1111, 1'b1, 1'b0);
    #1;
    check("stall_release", 8'(grant), 8'h04);
    cycle();

    // 5. skip idle channels from ptr 1
    drive(4'b0001, 1'b1, 1'b0);
    cycle();
    drive(4'b1001, 1'b1, 1'b0);
    #1;
    check("skip_D", 8'(grant), 8'h08);
    cycle();
    #1;
    check("skip_A", 8'(grant), 8'h01);
    cycle();
    drive(4'b0000, 1'b1, 1'b0);
    cycle();
    check("idle_clear", 8'(out_valid), 8'h00);

    // 6. reset during a stall discards the held word
    InD = 4'h9;
    drive(4'b1000, 1'b1, 1'b0);
    cycle();
    drive(4'b1111, 1'b0, 1'b0);
    cycle();
    drive(4'b1111, 1'b0, 1'b1);
    cycle();
    check("rst_stall_valid", 8'(out_valid), 8'h00);
    check("rst_stall_out", 8'(Out), 8'h00);
    drive(4'b1111, 1'b1, 1'b0);
    #1;
    check("rst_stall_ptr", 8'(grant), 8'h01);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      InA = N'($urandom); InB = N'($urandom);
      InC = N'($urandom); InD = N'($urandom);
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 40) == 0));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
